intpol2_d4_out_drain: RTL and testbench

//  Read side of the interpolator output FIFO: pops interpolated samples at a programmable output rate
//  and presents them to the DAC/consumer as a strobed stream. Pairs with the interpolator FSM, which

---
 rtl/intpol2_d4_out_drain_pkg.sv | 11 +
 rtl/intpol2_d4_out_drain_if.sv | 23 ++
 rtl/intpol2_rate_tick.sv | 25 ++
 rtl/intpol2_d4_out_drain.sv | 109 ++++++++++
 tb/tb_intpol2_d4_out_drain.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/intpol2_d4_out_drain_pkg.sv
// Shared types for the interpolator output-FIFO drain: state encoding and default widths.
package intpol2_d4_out_drain_pkg;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned DIV_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;
endpackage

// File: rtl/intpol2_d4_out_drain_if.sv
// FIFO read side plus strobed sample stream; master = drain, slave = FIFO/consumer side.
interface intpol2_d4_out_drain_if
    import intpol2_d4_out_drain_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_re;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              underflow;

    modport master (
        input  fifo_empty, fifo_rdata,
        output fifo_re, dout, dout_valid, underflow
    );

    modport slave (
        output fifo_empty, fifo_rdata,
        input  fifo_re, dout, dout_valid, underflow
    );
endinterface

// File: rtl/intpol2_rate_tick.sv
// Output-rate down-counter: tick while count is zero, reload on tick, clear forces an immediate tick.
module intpol2_rate_tick
    import intpol2_d4_out_drain_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [DIV_W-1:0] reload,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;

    assign tick = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? reload : cnt - DIV_W'(1);
        end
    end
endmodule

// File: rtl/intpol2_d4_out_drain.sv
// Interpolator output-FIFO drain: rate-paced pops, repeat-and-flag on underflow.
// Optional INTPOL_UFLOW_CNT_EN adds a saturating underflow counter output.
module intpol2_d4_out_drain
    import intpol2_d4_out_drain_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DIV_W  = DIV_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [DIV_W-1:0]       rate_div,
    intpol2_d4_out_drain_if.master bus,
    output logic                   busy,
    output logic                   done
`ifdef INTPOL_UFLOW_CNT_EN
    ,
    output logic [15:0]            uflow_cnt
`endif
);
    state_t            state, state_nx;
    logic [DIV_W-1:0]  div_q;
    logic              rd_pend, uf_pend;
    logic [DATA_W-1:0] dout_q;
    logic              tick, cnt_clear, cnt_en, pop, uf;

    intpol2_rate_tick #(.DIV_W(DIV_W)) u_rate_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .en     (cnt_en),
        .reload (div_q),
        .tick   (tick)
    );

    // start outranks stop, stop outranks a tick; a pop is never issued during reset
    always_comb begin
        state_nx  = state;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        pop       = 1'b0;
        uf        = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (start) state_nx = PRIME;
                end
                PRIME: begin
                    if (start) begin
                        state_nx = PRIME;
                    end else if (stop) begin
                        state_nx = IDLE;
                    end else if (!bus.fifo_empty) begin
                        state_nx  = RUN;
                        cnt_clear = 1'b1;
                    end
                end
                RUN: begin
                    if (start) begin
                        state_nx = PRIME;
                    end else if (stop) begin
                        state_nx = IDLE;
                    end else begin
                        cnt_en = 1'b1;
                        pop    = tick & ~bus.fifo_empty;
                        uf     = tick &  bus.fifo_empty;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div_q   <= '0;
            rd_pend <= 1'b0;
            uf_pend <= 1'b0;
            dout_q  <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            rd_pend <= pop;
            uf_pend <= uf;
            done    <= (state != IDLE) && stop && !start;
            if (start)   div_q  <= rate_div;
            if (rd_pend) dout_q <= bus.fifo_rdata;
        end
    end

    // FIFO data arrives the cycle after the pop, so the strobe cycle passes it straight through
    assign bus.fifo_re    = pop;
    assign bus.dout       = rd_pend ? bus.fifo_rdata : dout_q;
    assign bus.dout_valid = rd_pend | uf_pend;
    assign bus.underflow  = uf_pend;
    assign busy           = (state != IDLE);

`ifdef INTPOL_UFLOW_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || start) begin
            uflow_cnt <= '0;
        end else if (uf_pend && uflow_cnt != 16'hFFFF) begin
            uflow_cnt <= uflow_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_intpol2_d4_out_drain.sv
// Directed bench for intpol2_d4_out_drain with a small FIFO model driving the interface.
module tb_intpol2_d4_out_drain;
    localparam int unsigned DW = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] rate_div = '0;
    logic        busy, done;
`ifdef INTPOL_UFLOW_CNT_EN
    logic [15:0] uflow_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [16];
    int unsigned   wr_ptr = 0;
    int unsigned   rd_ptr = 0;
    logic          flush = 1'b0;
    logic [DW-1:0] exp_d [3];

    intpol2_d4_out_drain_if #(.DATA_W(DW)) bus ();

    intpol2_d4_out_drain #(.DATA_W(DW), .DIV_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .rate_div  (rate_div),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
`ifdef INTPOL_UFLOW_CNT_EN
        ,
        .uflow_cnt (uflow_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (bus.fifo_re) begin
            bus.fifo_rdata <= mem[rd_ptr % 16];
            rd_ptr         <= rd_ptr + 1;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] v);
        mem[wr_ptr % 16] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        nxt();
        flush = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        repeat (3) nxt();
        chk("rst_fifo_re", 32'(bus.fifo_re), 0);
        chk("rst_dout", 32'(bus.dout), 0);
        chk("rst_valid", 32'(bus.dout_valid), 0);
        chk("rst_uflow", 32'(bus.underflow), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
`ifdef INTPOL_UFLOW_CNT_EN
        chk("rst_ucnt", 32'(uflow_cnt), 0);
`endif
        rst = 1'b0;
        nxt();

        // 1: rate_div=3, pops every 4 cycles, rate_div change mid-run ignored
        push(16'd10); push(16'd20); push(16'd30);
        exp_d[0] = 16'd10; exp_d[1] = 16'd20; exp_d[2] = 16'd30;
        rate_div = 16'd3;
        start = 1'b1;
        nxt();
        start = 1'b0;
        rate_div = 16'd7;
        chk("t1_busy_prime", 32'(busy), 1);
        nxt();
        for (int i = 0; i <= 10; i++) begin
            chk("t1_fifo_re", 32'(bus.fifo_re), 32'((i % 4 == 0) && i <= 8));
            chk("t1_valid", 32'(bus.dout_valid), 32'((i % 4 == 1) && i <= 9));
            chk("t1_uflow", 32'(bus.underflow), 0);
            if ((i % 4 == 1) && i <= 9) chk("t1_dout", 32'(bus.dout), 32'(exp_d[i / 4]));
            if (i == 10) stop = 1'b1;
            nxt();
        end
        stop = 1'b0;
        chk("t1_done", 32'(done), 1);
        chk("t1_busy_off", 32'(busy), 0);
        chk("t1_valid_off", 32'(bus.dout_valid), 0);
        nxt();
        chk("t1_done_pulse", 32'(done), 0);

        // 2: rate_div=0, two words then underflow, then refill
        push(16'h00A1); push(16'h00A2);
        rate_div = 16'd0;
        start = 1'b1;
        nxt();
        start = 1'b0;
        nxt();
        chk("t2_re0", 32'(bus.fifo_re), 1);
        chk("t2_v0", 32'(bus.dout_valid), 0);
        nxt();
        chk("t2_re1", 32'(bus.fifo_re), 1);
        chk("t2_v1", 32'(bus.dout_valid), 1);
        chk("t2_d1", 32'(bus.dout), 32'h00A1);
        nxt();
        chk("t2_re2", 32'(bus.fifo_re), 0);
        chk("t2_v2", 32'(bus.dout_valid), 1);
        chk("t2_d2", 32'(bus.dout), 32'h00A2);
        chk("t2_u2", 32'(bus.underflow), 0);
        nxt();
        chk("t2_v3", 32'(bus.dout_valid), 1);
        chk("t2_u3", 32'(bus.underflow), 1);
        chk("t2_d3_repeat", 32'(bus.dout), 32'h00A2);
        chk("t2_re3", 32'(bus.fifo_re), 0);
        push(16'h00A3);
        #1;
        chk("t2_re_refill", 32'(bus.fifo_re), 1);
        nxt();
        chk("t2_v4", 32'(bus.dout_valid), 1);
        chk("t2_u4", 32'(bus.underflow), 0);
        chk("t2_d4", 32'(bus.dout), 32'h00A3);
        chk("t2_re4", 32'(bus.fifo_re), 0);
        stop = 1'b1;
        nxt();
        stop = 1'b0;
        chk("t2_done", 32'(done), 1);
        chk("t2_stop_no_uflow", 32'(bus.dout_valid), 0);
        chk("t2_busy", 32'(busy), 0);
        nxt();

        // 3: start with empty FIFO waits in PRIME, first strobe immediate once data arrives
        rate_div = 16'd5;
        start = 1'b1;
        nxt();
        start = 1'b0;
        chk("t3_busy", 32'(busy), 1);
        chk("t3_re_a", 32'(bus.fifo_re), 0);
        nxt();
        chk("t3_re_b", 32'(bus.fifo_re), 0);
        chk("t3_v_b", 32'(bus.dout_valid), 0);
        nxt();
        push(16'h1234);
        #1;
        chk("t3_re_prime", 32'(bus.fifo_re), 0);
        nxt();
        chk("t3_re_run", 32'(bus.fifo_re), 1);
        nxt();
        chk("t3_v", 32'(bus.dout_valid), 1);
        chk("t3_d", 32'(bus.dout), 32'h1234);
        chk("t3_re_after", 32'(bus.fifo_re), 0);
        stop = 1'b1;
        nxt();
        stop = 1'b0;
        chk("t3_done", 32'(done), 1);
        nxt();

        // 4: stop coincident with tick while a read is pending
        push(16'h00B1); push(16'h00B2); push(16'h00B3);
        rate_div = 16'd0;
        start = 1'b1;
        nxt();
        start = 1'b0;
        nxt();
        chk("t4_re0", 32'(bus.fifo_re), 1);
        nxt();
        chk("t4_re1", 32'(bus.fifo_re), 1);
        stop = 1'b1;
        #1;
        chk("t4_re_stopped", 32'(bus.fifo_re), 0);
        chk("t4_v_pend", 32'(bus.dout_valid), 1);
        chk("t4_d_pend", 32'(bus.dout), 32'h00B1);
        nxt();
        stop = 1'b0;
        chk("t4_done", 32'(done), 1);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_v_after", 32'(bus.dout_valid), 0);
        chk("t4_re_after", 32'(bus.fifo_re), 0);
        nxt();
        chk("t4_done_pulse", 32'(done), 0);
        do_flush();

        // 5: reset mid-RUN with a read pending
        push(16'h00C1); push(16'h00C2);
        start = 1'b1;
        nxt();
        start = 1'b0;
        nxt();
        nxt();
        chk("t5_v_pre", 32'(bus.dout_valid), 1);
        rst = 1'b1;
        #1;
        chk("t5_re_rst", 32'(bus.fifo_re), 0);
        nxt();
        chk("t5_v", 32'(bus.dout_valid), 0);
        chk("t5_dout", 32'(bus.dout), 0);
        chk("t5_uflow", 32'(bus.underflow), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        chk("t5_re", 32'(bus.fifo_re), 0);
        rst = 1'b0;
        do_flush();

`ifdef INTPOL_UFLOW_CNT_EN
        // 6: underflow counter counts, clears on start, saturates
        push(16'h00D1);
        rate_div = 16'd0;
        start = 1'b1;
        nxt();
        start = 1'b0;
        repeat (7) nxt();
        stop = 1'b1;
        nxt();
        stop = 1'b0;
        chk("t6_ucnt5", 32'(uflow_cnt), 5);
        start = 1'b1;
        nxt();
        start = 1'b0;
        chk("t6_ucnt_clr", 32'(uflow_cnt), 0);
        push(16'h00D2);
        repeat (65545) nxt();
        chk("t6_ucnt_sat", 32'(uflow_cnt), 32'hFFFF);
        stop = 1'b1;
        nxt();
        stop = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
